ins_loader: RTL and testbench

INS_LOADER -- requirements
Module: ins_loader

---
 rtl/ins_loader.sv | 163 ++++++++++++++++
 tb/tb_ins_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_loader.sv
// ins_loader: encodes RV32 instruction requests (R/I/S/SB/UJ) and writes them
// sequentially into instruction memory starting at a latched base address.
//
// state  | meaning
// IDLE   | waiting for start; status outputs hold the previous session's result
// ACCEPT | in_ready high, waiting for an instruction request
// WRITE  | one-cycle memory write of the registered encoded word
// FINISH | one-cycle done pulse, then back to IDLE
module ins_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    state_t             state, state_nxt;
    logic               last_q;
    logic               hs;
    logic               max_hit;
    logic               enc_err;
    logic [31:0]        enc_word;
    logic signed [31:0] imm_s;
    logic               imm12_ok, imm13_ok, imm21_ok;

    assign imm_s    = in_imm;
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign imm13_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
    assign imm21_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
    assign hs       = in_valid && in_ready;
    assign max_hit  = (count + 16'd1) == MAX_CNT;

    // Encode the presented request and flag unencodable formats/immediates
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03};
                enc_err  = !imm12_ok;
            end
            3'd2: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
                enc_err  = !imm12_ok;
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23};
                enc_err  = !imm12_ok;
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'h63};
                enc_err  = !imm13_ok;
            end
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
                enc_err  = !imm21_ok;
            end
            default: enc_err = 1'b1;
        endcase
    end

    // Next-state and status outputs; reset masks the outputs in its own cycle
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                in_ready = !reset;
                busy     = !reset;
                if (hs) begin
                    if (enc_err) state_nxt = in_last ? FINISH : ACCEPT;
                    else         state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_we = !reset;
                busy   = !reset;
                if (last_q || max_hit) state_nxt = FINISH;
                else                   state_nxt = ACCEPT;
            end
            FINISH: begin
                done      = !reset;
                busy      = !reset;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Session datapath: address, write data, word count and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr & 32'hFFFF_FFFC;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (hs) begin
                        if (enc_err) begin
                            err <= 1'b1;
                        end else begin
                            mem_wdata <= enc_word;
                            last_q    <= in_last;
                        end
                    end
                end
                WRITE: begin
                    mem_addr <= mem_addr + 32'd4;
                    count    <= count + 16'd1;
                    if (!last_q && max_hit) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: transaction-level model of expected writes and session
// status, a per-cycle compare process, and directed sessions with literal checks.
module tb_ins_loader;

    localparam int MAXW = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        busy, done, err;
    logic [15:0] count;

    ins_loader #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          done_seen = 0;
    int          sess_done0 = 0;
    logic [31:0] m_addr;
    int          m_count;
    logic        m_err;
    wr_t         exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Instruction word built by shifting fields into place from the format rules
    function automatic logic [31:0] model_enc(input int fmt, input int rd, input int rs1,
                                              input int rs2, input int f3, input int f7,
                                              input int imm, output bit ok);
        logic [31:0] u;
        logic [31:0] w;
        u  = imm;
        w  = 0;
        ok = 1'b1;
        case (fmt)
            0: w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
            1, 2: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = ((fmt == 1) ? 32'h03 : 32'h13) | (rd << 7) | (f3 << 12) | (rs1 << 15)
                     | ((u & 32'hFFF) << 20);
            end
            3: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = 32'h23 | ((u & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                     | (((u >> 5) & 32'h7F) << 25);
            end
            4: begin
                ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
                w  = 32'h63 | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8)
                     | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                     | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
            end
            5: begin
                ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
                w  = 32'h6F | (rd << 7) | (((u >> 12) & 32'hFF) << 12)
                     | (((u >> 11) & 32'h1) << 20) | (((u >> 1) & 32'h3FF) << 21)
                     | (((u >> 20) & 32'h1) << 31);
            end
            default: ok = 1'b0;
        endcase
        return w;
    endfunction

    task automatic model_accept(input int fmt, input int rd, input int rs1, input int rs2,
                                input int f3, input int f7, input int imm, input int last);
        bit          ok;
        logic [31:0] w;
        w = model_enc(fmt, rd, rs1, rs2, f3, f7, imm, ok);
        if (!ok) begin
            m_err = 1'b1;
        end else begin
            exp_q.push_back(wr_t'{m_addr, w});
            m_addr  = m_addr + 32'd4;
            m_count++;
            if (last == 0 && m_count == MAXW) m_err = 1'b1;
        end
    endtask

    task automatic drive(input int fmt, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7, input int imm, input int last);
        in_fmt    = 3'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = imm;
        in_last   = 1'(last);
        in_valid  = 1'b1;
    endtask

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start      = 1'b1;
        base_addr  = b;
        m_addr     = b & 32'hFFFF_FFFC;
        m_count    = 0;
        m_err      = 1'b0;
        sess_done0 = done_seen;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", in_ready, 1);
    endtask

    // Returns on the negedge after the handshake edge (the write cycle if encodable)
    task automatic send(input int fmt, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm, input int last);
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(fmt, rd, rs1, rs2, f3, f7, imm, last);
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("handshake_timeout", 0, 1);
        else model_accept(fmt, rd, rs1, rs2, f3, f7, imm, last);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        check({nm, "_idle"}, idle, 1);
        check({nm, "_done_once"}, done_seen - sess_done0, 1);
    endtask

    // Every write must match the next modelled write; done reports modelled status
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        if (done) begin
            done_seen++;
            check("done_err", err, m_err);
            check("done_count", count, m_count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;
        logic [31:0] w;

        reset     = 1'b1;
        start     = 1'b1;
        base_addr = 32'h1234;
        drive(0, 3, 1, 2, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_we_done_err", {mem_we, done, err}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        reset = 1'b0;

        w = model_enc(0, 3, 1, 2, 0, 0, 0, ok);
        check("pin_r", w, 32'h002081B3);
        w = model_enc(4, 0, 1, 2, 0, 0, -8, ok);
        check("pin_sb", w, 32'hFE208CE3);
        w = model_enc(5, 1, 0, 0, 0, 0, 2048, ok);
        check("pin_uj", w, 32'h001000EF);
        w = model_enc(4, 0, 1, 2, 0, 0, -7, ok);
        check("pin_sb_odd_err", ok, 0);

        // Session A: R, I-load, S(last) from base 0x28
        do_start(32'h28);
        send(0, 3, 1, 2, 0, 0, 0, 0);
        check("a0_we", mem_we, 1);
        check("a0_addr", mem_addr, 32'h28);
        check("a0_data", mem_wdata, 32'h002081B3);
        start     = 1'b1;
        base_addr = 32'h900;
        @(negedge clk);
        start = 1'b0;
        check("a0_count", count, 1);
        send(1, 5, 0, 0, 2, 0, 8, 0);
        check("a1_addr", mem_addr, 32'h2C);
        check("a1_data", mem_wdata, 32'h00802283);
        send(3, 0, 0, 5, 2, 0, 12, 1);
        check("a2_addr", mem_addr, 32'h30);
        check("a2_data", mem_wdata, 32'h00502623);
        wait_idle("a");
        check("a_count", count, 3);
        check("a_err", err, 0);

        // Session B: branches and encode errors, ending on an error with last
        do_start(32'h103);
        send(4, 0, 1, 2, 0, 0, -8, 0);
        check("b0_addr", mem_addr, 32'h100);
        check("b0_data", mem_wdata, 32'hFE208CE3);
        send(4, 0, 1, 2, 0, 0, -7, 0);
        check("b1_no_we", mem_we, 0);
        check("b1_err", err, 1);
        check("b1_count", count, 1);
        send(2, 7, 7, 0, 0, 0, -2048, 0);
        send(1, 1, 1, 0, 0, 0, 2048, 0);
        send(7, 0, 0, 0, 0, 0, 0, 1);
        wait_idle("b");
        check("b_count", count, 2);
        check("b_err", err, 1);

        // Session C: word limit reached with no last, address wraps past zero
        do_start(32'hFFFF_FFF8);
        send(5, 1, 0, 0, 0, 0, 2048, 0);
        check("c0_data", mem_wdata, 32'h001000EF);
        send(5, 0, 0, 0, 0, 0, -1048576, 0);
        send(0, 1, 2, 3, 4, 7'h20, 0, 0);
        send(2, 1, 1, 0, 0, 0, -1, 0);
        @(negedge clk);
        drive(0, 9, 9, 9, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("c_fifth_never_ready", seen, 0);
        check("c_count", count, 4);
        check("c_err", err, 1);
        wait_idle("c");

        // Session D: reset in the cycle after a handshake, then restart elsewhere
        do_start(32'h40);
        @(negedge clk);
        drive(0, 3, 1, 2, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("d_handshake", seen, 1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("d_we_in_reset", mem_we, 0);
        @(posedge clk);
        #1;
        check("d_busy", busy, 0);
        check("d_ready_we_done_err", {in_ready, mem_we, done, err}, 0);
        check("d_addr", mem_addr, 0);
        check("d_wdata", mem_wdata, 0);
        check("d_count", count, 0);
        @(negedge clk);
        reset = 1'b0;
        do_start(32'h80);
        send(0, 3, 1, 2, 0, 0, 0, 1);
        check("d_new_addr", mem_addr, 32'h80);
        wait_idle("d");
        check("d_final_count", count, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
